rob_multiway: RTL

//  Parametrised reorder buffer: DISPATCH_W allocations, CDB_W completions and COMMIT_W
//  in-order retirements per cycle. Sits between dispatcher, CDB and arch regfile/fetch.

---
 rtl/rob_multiway.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rob_multiway.sv
// Multi-way reorder buffer with wide dispatch, CDB completion and operand bypass.
// Retires in order, several entries per cycle, and squashes everything on a committing mispredict.
module rob_multiway #(
   parameter int DEPTH      = 16,
   parameter int DISPATCH_W = 2,
   parameter int COMMIT_W   = 2,
   parameter int CDB_W      = 2,
   parameter int XLEN       = 32,
   parameter int REG_W      = 5,
   localparam int TAG_W     = $clog2(DEPTH),
   localparam int SRCH_N    = 2*DISPATCH_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DISPATCH_W-1:0]       disp_valid,
   input  logic [DISPATCH_W*REG_W-1:0] disp_reg,
   input  logic [DISPATCH_W*XLEN-1:0]  disp_npc,
   output logic [DISPATCH_W*TAG_W-1:0] disp_tag,
   output logic                        disp_ready,
   input  logic [CDB_W-1:0]            cdb_valid,
   input  logic [CDB_W*TAG_W-1:0]      cdb_tag,
   input  logic [CDB_W*XLEN-1:0]       cdb_data,
   input  logic [CDB_W-1:0]            cdb_mispred,
   input  logic [CDB_W*XLEN-1:0]       cdb_target,
   input  logic [SRCH_N*TAG_W-1:0]     srch_tag,
   output logic [SRCH_N*XLEN-1:0]      srch_data,
   output logic [SRCH_N-1:0]           srch_ready,
   output logic [COMMIT_W-1:0]         cmt_valid,
   output logic [COMMIT_W*REG_W-1:0]   cmt_reg,
   output logic [COMMIT_W*XLEN-1:0]    cmt_data,
   output logic [COMMIT_W*TAG_W-1:0]   cmt_tag,
   output logic                        flush,
   output logic [XLEN-1:0]             flush_pc,
   output logic [TAG_W:0]              count,
   output logic                        empty
);

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_ready;
   logic [DEPTH-1:0] r_mispred;
   logic [REG_W-1:0] r_reg  [DEPTH];
   logic [XLEN-1:0]  r_data [DEPTH];
   logic [XLEN-1:0]  r_npc  [DEPTH];
   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [TAG_W:0]   r_count;

   logic [TAG_W:0]   w_n_disp;
   logic [TAG_W:0]   w_n_acc;
   logic [TAG_W:0]   w_n_cmt;
   logic             w_disp_ok;
   logic             w_stop;
   logic [TAG_W-1:0] w_cidx;
   logic [TAG_W-1:0] w_stag;

   assign count      = r_count;
   assign empty      = (r_count == '0);
   // Registered count only: same-cycle retirements give no dispatch credit.
   assign disp_ready = (r_count <= (TAG_W+1)'(DEPTH - DISPATCH_W));
   assign w_disp_ok  = disp_ready && !flush;
   assign w_n_acc    = w_disp_ok ? w_n_disp : '0;

   always_comb begin
      w_n_disp = '0;
      disp_tag = '0;
      for (int i = 0; i < DISPATCH_W; i++) begin
         disp_tag[i*TAG_W +: TAG_W] = r_tail + w_n_disp[TAG_W-1:0];
         w_n_disp = w_n_disp + {{TAG_W{1'b0}}, disp_valid[i]};
      end
   end

   // Retire a contiguous prefix of ready entries; a mispredicted entry retires and ends the group.
   always_comb begin
      cmt_valid = '0;
      cmt_reg   = '0;
      cmt_data  = '0;
      cmt_tag   = '0;
      flush     = 1'b0;
      flush_pc  = '0;
      w_n_cmt   = '0;
      w_stop    = 1'b0;
      w_cidx    = r_head;
      for (int k = 0; k < COMMIT_W; k++) begin
         w_cidx = r_head + TAG_W'(k);
         if (!w_stop && r_valid[w_cidx] && r_ready[w_cidx]) begin
            cmt_valid[k]                = 1'b1;
            cmt_reg[k*REG_W +: REG_W]   = r_reg[w_cidx];
            cmt_data[k*XLEN +: XLEN]    = r_data[w_cidx];
            cmt_tag[k*TAG_W +: TAG_W]   = w_cidx;
            w_n_cmt = w_n_cmt + (TAG_W+1)'(1);
            if (r_mispred[w_cidx]) begin
               flush    = 1'b1;
               flush_pc = r_npc[w_cidx];
               w_stop   = 1'b1;
            end
         end else begin
            w_stop = 1'b1;
         end
      end
   end

   always_comb begin
      srch_data  = '0;
      srch_ready = '0;
      w_stag     = '0;
      for (int s = 0; s < SRCH_N; s++) begin
         w_stag = srch_tag[s*TAG_W +: TAG_W];
         if (r_valid[w_stag]) begin
            srch_data[s*XLEN +: XLEN] = r_data[w_stag];
            srch_ready[s]             = r_ready[w_stag];
         end
         for (int j = 0; j < CDB_W; j++) begin
            if (cdb_valid[j] && (cdb_tag[j*TAG_W +: TAG_W] == w_stag)) begin
               srch_data[s*XLEN +: XLEN] = cdb_data[j*XLEN +: XLEN];
               srch_ready[s]             = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid   <= '0;
         r_ready   <= '0;
         r_mispred <= '0;
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
      end else if (flush) begin
         r_valid   <= '0;
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
      end else begin
         // Ascending port order lets the higher port win on equal tags.
         for (int j = 0; j < CDB_W; j++) begin
            if (cdb_valid[j] && r_valid[cdb_tag[j*TAG_W +: TAG_W]]) begin
               r_ready[cdb_tag[j*TAG_W +: TAG_W]]   <= 1'b1;
               r_mispred[cdb_tag[j*TAG_W +: TAG_W]] <= cdb_mispred[j];
            end
         end
         for (int k = 0; k < COMMIT_W; k++) begin
            if (cmt_valid[k]) r_valid[r_head + TAG_W'(k)] <= 1'b0;
         end
         if (w_disp_ok) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
               if (disp_valid[i]) begin
                  r_valid[disp_tag[i*TAG_W +: TAG_W]]   <= 1'b1;
                  r_ready[disp_tag[i*TAG_W +: TAG_W]]   <= 1'b0;
                  r_mispred[disp_tag[i*TAG_W +: TAG_W]] <= 1'b0;
               end
            end
         end
         r_head  <= r_head + w_n_cmt[TAG_W-1:0];
         r_tail  <= r_tail + w_n_acc[TAG_W-1:0];
         r_count <= r_count + w_n_acc - w_n_cmt;
      end
   end

   // Payload fields carry no reset; they are only observed through valid entries.
   always_ff @(posedge clk) begin
      if (!flush) begin
         for (int j = 0; j < CDB_W; j++) begin
            if (cdb_valid[j] && r_valid[cdb_tag[j*TAG_W +: TAG_W]]) begin
               r_data[cdb_tag[j*TAG_W +: TAG_W]] <= cdb_data[j*XLEN +: XLEN];
               if (cdb_mispred[j])
                  r_npc[cdb_tag[j*TAG_W +: TAG_W]] <= cdb_target[j*XLEN +: XLEN];
            end
         end
         if (w_disp_ok) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
               if (disp_valid[i]) begin
                  r_reg[disp_tag[i*TAG_W +: TAG_W]]  <= disp_reg[i*REG_W +: REG_W];
                  r_npc[disp_tag[i*TAG_W +: TAG_W]]  <= disp_npc[i*XLEN +: XLEN];
                  r_data[disp_tag[i*TAG_W +: TAG_W]] <= '0;
               end
            end
         end
      end
   end

endmodule
